// File: rtl/i2c_eeprom_backend_pkg.sv
// Shared constants for the I2C EEPROM backend: byte width, reset fill value
// and FSM state encodings.
package i2c_eeprom_backend_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] INIT_VAL_DEF = 8'hFF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/i2c_eeprom_backend_page_buf.sv
// Page write buffer: 2**PAGE_W bytes with a per-slot valid mask, a random
// write port and a combinational read port used to drain the page.
module i2c_page_buf
  import i2c_eeprom_backend_pkg::*;
#(
  parameter int PAGE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [PAGE_W-1:0] wr_off_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic [PAGE_W-1:0] rd_off_i,
  output logic [BYTE_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              any_valid_o
);

  localparam int DEPTH = 2**PAGE_W;

  logic [BYTE_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  mask_q;
  logic [DEPTH-1:0]  mask_d;

  // A write in the same cycle as a clear still marks its slot.
  always_comb begin
    mask_d = clr_i ? '0 : mask_q;
    if (wr_en_i) mask_d[wr_off_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[wr_off_i] <= wr_data_i;
  end

  assign rd_data_o   = data_q[rd_off_i];
  assign rd_valid_o  = mask_q[rd_off_i];
  assign any_valid_o = |mask_q;

endmodule

// File: rtl/i2c_eeprom_backend.sv
// 24Cxx-style byte memory behind an I2C slave: pointer load, paged write
// buffering, commit on STOP/RESTART, auto-incrementing sequential reads.
module i2c_eeprom_backend
  import i2c_eeprom_backend_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              PAGE_W   = 3,
  parameter logic [BYTE_W-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hitar,
  input  logic              flag_start,
  input  logic              flag_restart,
  input  logic              flag_stop,
  input  logic              write_en,
  input  logic [BYTE_W-1:0] write_data,
  input  logic              read_en,
  output logic [BYTE_W-1:0] read_data,
  output logic              busy,
  output logic              commit_done,
  output logic [ADDR_W-1:0] ptr,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int PG_W  = ADDR_W - PAGE_W;
  localparam logic [PAGE_W-1:0] LAST_OFF = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [PG_W-1:0]   page_q, page_d;
  logic [PAGE_W-1:0] off_q, off_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] read_data_q;

  logic              wr_ok, rd_ok, end_evt;
  logic              buf_clr, buf_wr, mem_we, done_c;
  logic [BYTE_W-1:0] buf_rd_data;
  logic              buf_rd_valid, buf_any;

  // Handshake: write_en/read_en are single-cycle strobes, qualified by hitar;
  // there is no back-pressure, so each accepted strobe acts on this edge.
  assign wr_ok   = hitar & write_en;
  assign rd_ok   = hitar & read_en;
  assign end_evt = flag_stop | flag_restart | flag_start;

  i2c_page_buf #(.PAGE_W(PAGE_W)) u_page_buf (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (buf_clr),
    .wr_en_i     (buf_wr),
    .wr_off_i    (ptr_q[PAGE_W-1:0]),
    .wr_data_i   (write_data),
    .rd_off_i    (off_q),
    .rd_data_o   (buf_rd_data),
    .rd_valid_o  (buf_rd_valid),
    .any_valid_o (buf_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    page_d  = page_q;
    off_d   = off_q;
    buf_clr = 1'b0;
    buf_wr  = 1'b0;
    mem_we  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_ok) begin
          ptr_d   = ADDR_W'(write_data);
          buf_clr = 1'b1;
          state_d = ST_DATA;
        end else if (rd_ok) begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_DATA: begin
        if (wr_ok) begin
          buf_wr = 1'b1;
          ptr_d  = {ptr_q[ADDR_W-1:PAGE_W], ptr_q[PAGE_W-1:0] + PAGE_W'(1)};
        end else if (rd_ok) begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
        // A byte arriving with STOP/RESTART counts toward the commit decision.
        if (end_evt) begin
          if (buf_any || wr_ok) begin
            state_d = ST_COMMIT;
            page_d  = ptr_q[ADDR_W-1:PAGE_W];
            off_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        mem_we = buf_rd_valid;
        off_d  = off_q + PAGE_W'(1);
        if (off_q == LAST_OFF) begin
          done_c  = 1'b1;
          buf_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      page_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      page_q  <= page_d;
      off_q   <= off_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VAL;
    end else if (mem_we) begin
      mem_q[{page_q, off_q}] <= buf_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) read_data_q <= INIT_VAL;
    else     read_data_q <= mem_q[ptr_q];
  end

  assign read_data   = read_data_q;
  assign busy        = (state_q == ST_COMMIT);
  assign commit_done = done_c;
  assign ptr         = ptr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_eeprom_backend.sv
// Bench for i2c_eeprom_backend: directed 24Cxx scenarios plus random
// transactions, checked every cycle against a transaction-level memory model.
module tb_i2c_eeprom_backend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hitar = 1'b0;
  logic       flag_start = 1'b0, flag_restart = 1'b0, flag_stop = 1'b0;
  logic       write_en = 1'b0, read_en = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic [7:0] read_data;
  logic       busy, commit_done;
  logic [7:0] ptr;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  i2c_eeprom_backend dut (
    .clk          (clk),
    .rst          (rst),
    .hitar        (hitar),
    .flag_start   (flag_start),
    .flag_restart (flag_restart),
    .flag_stop    (flag_stop),
    .write_en     (write_en),
    .write_data   (write_data),
    .read_en      (read_en),
    .read_data    (read_data),
    .busy         (busy),
    .commit_done  (commit_done),
    .ptr          (ptr),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [256];
  logic [7:0] m_buf [8];
  bit         m_valid [8];
  logic [7:0] m_ptr = 8'h00;
  bit         m_loaded = 1'b0;   // pointer byte received, collecting data
  int         m_left = 0;        // commit cycles remaining
  logic [4:0] m_page = 5'd0;
  logic [7:0] exp_rd = 8'hFF, exp_ptr = 8'h00;
  bit         exp_busy = 1'b0, exp_done = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] old_ptr;
    int         off;
    bit         anyv;
    old_ptr = m_ptr;
    if (m_left > 0 && (write_en || read_en)) begin
      n_err++;
      $display("FAIL protocol: strobe during commit got we=%0b re=%0b want 0", write_en, read_en);
    end
    if (rst) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_ptr = 8'h00; m_loaded = 1'b0; m_left = 0; exp_rd = 8'hFF;
    end else begin
      exp_rd = m_mem[m_ptr];
      if (m_left > 0) begin
        off = 8 - m_left;
        if (m_valid[off]) m_mem[m_page * 8 + off] = m_buf[off];
        m_left--;
        if (m_left == 0) for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      end else if (!m_loaded) begin
        if (hitar && write_en) begin
          m_ptr = write_data; m_loaded = 1'b1;
          for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        end else if (hitar && read_en) begin
          m_ptr = m_ptr + 8'd1;
        end
      end else begin
        if (hitar && write_en) begin
          m_buf[m_ptr % 8] = write_data;
          m_valid[m_ptr % 8] = 1'b1;
          m_ptr = (m_ptr & 8'hF8) | ((m_ptr + 8'd1) & 8'h07);
        end else if (hitar && read_en) begin
          m_ptr = m_ptr + 8'd1;
        end
        if (flag_stop || flag_restart || flag_start) begin
          m_loaded = 1'b0;
          anyv = 1'b0;
          for (int i = 0; i < 8; i++) anyv |= m_valid[i];
          if (anyv) begin m_left = 8; m_page = old_ptr[7:3]; end
        end
      end
    end
    exp_busy = (m_left > 0);
    exp_done = (m_left == 1);
    exp_ptr  = m_ptr;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #2;
    check("read_data", {24'd0, read_data}, {24'd0, exp_rd});
    check("ptr", {24'd0, ptr}, {24'd0, exp_ptr});
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check("commit_done", {31'd0, commit_done}, {31'd0, exp_done});
    if (commit_done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic begin_txn();
    flag_start = 1'b1;
    @(negedge clk);
    flag_start = 1'b0;
    hitar = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    write_en = 1'b1; write_data = b;
    @(negedge clk);
    write_en = 1'b0;
    gap();
  endtask

  // kind: 0 STOP, 1 RESTART, 2 STOP with last byte, 3 STOP with a read
  task automatic end_txn(input int kind, input logic [7:0] b, output int cyc);
    case (kind)
      1: flag_restart = 1'b1;
      2: begin flag_stop = 1'b1; write_en = 1'b1; write_data = b; end
      3: begin flag_stop = 1'b1; read_en = 1'b1; end
      default: flag_stop = 1'b1;
    endcase
    @(negedge clk);
    flag_stop = 1'b0; flag_restart = 1'b0; write_en = 1'b0; read_en = 1'b0;
    hitar = (kind == 1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      flag_start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    flag_start = 1'b0;
    if (cyc >= 40) begin
      n_vec++; n_err++;
      $display("FAIL commit_timeout: got busy after %0d cycles want idle", cyc);
    end
  endtask

  task automatic rd_byte();
    logic [7:0] e;
    e = exp_q.pop_front();
    check("readback", {24'd0, read_data}, {24'd0, e});
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    gap();
  endtask

  task automatic set_ptr(input logic [7:0] p);
    int c;
    begin_txn();
    wr_byte(p);
    end_txn(1, 8'h00, c);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int         cyc, d0, nb, kind;
    logic [7:0] t2 [8];
    logic [7:0] rv;
    t2[0] = 8'hC0; t2[1] = 8'hB0; t2[2] = 8'hA0; t2[3] = 8'hCC;
    t2[4] = 8'hEF; t2[5] = 8'hCD; t2[6] = 8'hB2; t2[7] = 8'hA0;

    repeat (3) @(negedge clk);
    check("rst_ptr", {24'd0, ptr}, 32'h0);
    check("rst_read_data", {24'd0, read_data}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte write
    begin_txn();
    wr_byte(8'h01);
    wr_byte(8'h02);
    d0 = done_cnt;
    end_txn(0, 8'h00, cyc);
    check("t1_busy_cycles", cyc, 32'd8);
    check("t1_done_pulses", done_cnt - d0, 32'd1);
    check("t1_ptr", {24'd0, ptr}, 32'h02);
    check("t1_model_mem", {24'd0, m_mem[1]}, 32'h02);

    // 4: random read, no commit on RESTART
    begin_txn();
    wr_byte(8'h01);
    end_txn(1, 8'h00, cyc);
    check("t4_no_commit", cyc, 32'd0);
    @(negedge clk);
    exp_q.push_back(8'h02); exp_q.push_back(8'hFF);
    rd_byte(); rd_byte();
    check("t4_ptr", {24'd0, ptr}, 32'h03);
    end_txn(0, 8'h00, cyc);

    // 2: full page
    begin_txn();
    wr_byte(8'h00);
    for (int i = 0; i < 8; i++) wr_byte(t2[i]);
    end_txn(0, 8'h00, cyc);
    set_ptr(8'h00);
    for (int i = 0; i < 8; i++) exp_q.push_back(t2[i]);
    for (int i = 0; i < 8; i++) rd_byte();
    end_txn(0, 8'h00, cyc);

    // 3: page wrap
    begin_txn();
    wr_byte(8'h06);
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
    end_txn(0, 8'h00, cyc);
    check("t3_ptr", {24'd0, ptr}, 32'h02);
    set_ptr(8'h00);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'hA0);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hEF); exp_q.push_back(8'hCD);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    for (int i = 0; i < 8; i++) rd_byte();
    end_txn(0, 8'h00, cyc);

    // 5: sequential read across 0xFF -> 0x00
    set_ptr(8'hFE);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'h33);
    for (int i = 0; i < 3; i++) rd_byte();
    check("t5_ptr", {24'd0, ptr}, 32'h01);
    end_txn(0, 8'h00, cyc);

    // 6: reset mid-transaction drops buffered bytes
    begin_txn();
    wr_byte(8'h10);
    wr_byte(8'h55); wr_byte(8'h66); wr_byte(8'h77);
    rst = 1'b1; hitar = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_ptr", {24'd0, ptr}, 32'h00);
    check("t6_busy", {31'd0, busy}, 32'h0);
    check("t6_read_data", {24'd0, read_data}, 32'hFF);
    @(negedge clk);
    set_ptr(8'h10);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'hFF);
    for (int i = 0; i < 3; i++) rd_byte();
    end_txn(0, 8'h00, cyc);

    // simultaneous write+STOP, then read+STOP
    begin_txn();
    wr_byte(8'h20);
    end_txn(2, 8'h9A, cyc);
    check("sim_wr_stop_commit", cyc, 32'd8);
    set_ptr(8'h20);
    end_txn(3, 8'h00, cyc);
    check("sim_rd_stop_ptr", {24'd0, ptr}, 32'h21);
    check("sim_wr_stop_mem", {24'd0, m_mem[8'h20]}, 32'h9A);

    // random transactions; the per-cycle compare carries the checking
    for (int t = 0; t < 60; t++) begin
      begin_txn();
      if ($urandom_range(0, 4) == 0) begin
        // current-address reads from IDLE
        repeat ($urandom_range(1, 4)) begin
          read_en = 1'b1; @(negedge clk); read_en = 1'b0; gap();
        end
        end_txn(0, 8'h00, cyc);
        continue;
      end
      wr_byte(8'($urandom_range(0, 255)));
      nb = $urandom_range(0, 11);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          hitar = 1'b0; write_en = 1'b1; write_data = 8'hEE;
          @(negedge clk);
          write_en = 1'b0; hitar = 1'b1;
        end
        wr_byte(8'($urandom_range(0, 255)));
      end
      kind = $urandom_range(0, 3);
      rv = 8'($urandom_range(0, 255));
      end_txn(kind, rv, cyc);
      if (kind == 1) begin
        @(negedge clk);
        repeat ($urandom_range(0, 5)) begin
          read_en = 1'b1; @(negedge clk); read_en = 1'b0; gap();
        end
        end_txn(0, 8'h00, cyc);
      end
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_err++;
    $display("FAIL watchdog: got no finish want finish before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
